avalon_multi_interval_timer: RTL

//   Parametrised multi-channel Avalon-MM interval timer: NUM_CH independent down-counters, each with its own

---
 rtl/avalon_multi_interval_timer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/avalon_multi_interval_timer.sv
// Multi-channel Avalon-MM interval timer: NUM_CH independent down-counters, each with a
// prescaler, one-shot or continuous mode, a snapshot register and an interrupt.

module avalon_mit_channel #(
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_i,
  input  logic [2:0]  reg_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
  logic [PRE_W-1:0] pre_q, pre_d, pre_cnt_q, pre_cnt_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             run_q, run_d, to_q, to_d, zero_q, reload_q;
  logic             wr_status, wr_ctrl, wr_period, wr_snap, wr_pre;
  logic             start, stop, tick, cnt_zero;
  logic             unused_wdata;

  assign unused_wdata = ^wdata_i;

  assign wr_status = wr_i && (reg_i == 3'd0);
  assign wr_ctrl   = wr_i && (reg_i == 3'd1);
  assign wr_period = wr_i && (reg_i == 3'd2);
  assign wr_snap   = wr_i && (reg_i == 3'd3);
  assign wr_pre    = wr_i && (reg_i == 3'd4);
  assign start     = wr_ctrl && wdata_i[2];
  assign stop      = wr_ctrl && wdata_i[3] && !wdata_i[2];
  assign cnt_zero  = (cnt_q == '0);
  assign tick      = run_q && (pre_cnt_q == pre_q);

  always_comb begin
    ctrl_d    = wr_ctrl   ? wdata_i[3:0]       : ctrl_q;
    period_d  = wr_period ? wdata_i[CNT_W-1:0] : period_q;
    pre_d     = wr_pre    ? wdata_i[PRE_W-1:0] : pre_q;
    snap_d    = wr_snap   ? cnt_q              : snap_q;

    pre_cnt_d = pre_cnt_q + 1'b1;
    if (!run_q || start || wr_period || tick) pre_cnt_d = '0;

    // A pending PERIOD write overrides any tick so the new period loads cleanly.
    cnt_d = cnt_q;
    if (reload_q)  cnt_d = period_q;
    else if (tick) cnt_d = cnt_zero ? period_q : cnt_q - 1'b1;

    run_d = run_q;
    if (reload_q || wr_period || stop || (tick && cnt_zero && !ctrl_q[1])) run_d = 1'b0;
    if (start) run_d = 1'b1;

    // Clear has priority over a coincident zero-edge.
    to_d = wr_status ? 1'b0 : (to_q || (cnt_zero && !zero_q));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= CNT_W'(RESET_PERIOD);
      period_q  <= CNT_W'(RESET_PERIOD);
      snap_q    <= '0;
      pre_q     <= '0;
      pre_cnt_q <= '0;
      ctrl_q    <= '0;
      run_q     <= 1'b0;
      to_q      <= 1'b0;
      zero_q    <= 1'b0;
      reload_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      snap_q    <= snap_d;
      pre_q     <= pre_d;
      pre_cnt_q <= pre_cnt_d;
      ctrl_q    <= ctrl_d;
      run_q     <= run_d;
      to_q      <= to_d;
      zero_q    <= cnt_zero;
      reload_q  <= wr_period;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (reg_i)
      3'd0:    rdata_o = {30'd0, run_q, to_q};
      3'd1:    rdata_o = {28'd0, ctrl_q};
      3'd2:    rdata_o = 32'(period_q);
      3'd3:    rdata_o = 32'(snap_q);
      3'd4:    rdata_o = 32'(pre_q);
      default: rdata_o = '0;
    endcase
  end

  assign irq_o = to_q && ctrl_q[0];
endmodule

module avalon_multi_interval_timer #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 49999,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CH_W+2:0]   address_i,
  input  logic              chipselect_i,
  input  logic              write_n_i,
  input  logic [31:0]       writedata_i,
  output logic [31:0]       readdata_o,
  output logic [NUM_CH-1:0] irq_o,
  output logic              irq_any_o
);
  logic [CH_W-1:0]              ch;
  logic [2:0]                   rsel;
  logic                         wr;
  logic [NUM_CH-1:0][31:0]      ch_rdata;
  logic [NUM_CH-1:0]            ch_irq;
  logic [31:0]                  readdata_d, readdata_q;

  assign ch   = address_i[CH_W+2:3];
  assign rsel = address_i[2:0];
  assign wr   = chipselect_i && !write_n_i;

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    avalon_mit_channel #(
      .CNT_W(CNT_W), .PRE_W(PRE_W), .RESET_PERIOD(RESET_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_i    (wr && (ch == CH_W'(g))),
      .reg_i   (rsel),
      .wdata_i (writedata_i),
      .rdata_o (ch_rdata[g]),
      .irq_o   (ch_irq[g])
    );
  end

  // Channel indices past NUM_CH match nothing and read back 0.
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch == CH_W'(i)) readdata_d = ch_rdata[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata_o = readdata_q;
  assign irq_o      = ch_irq;
  assign irq_any_o  = |ch_irq;
endmodule
